// File: rtl/div_share_ctrl_pkg.sv
// Shared types and constants for the divider-sharing controller.
package div_share_pkg;

  localparam int TMR_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LAUNCH = 4'b0010,
    ST_WAIT   = 4'b0100,
    ST_RESP   = 4'b1000
  } state_t;

  // Wide enough for any W in use; callers slice the low W bits.
  localparam logic [63:0] DIV0_RESULT    = '1;
  localparam logic [63:0] TIMEOUT_RESULT = '0;

endpackage

// File: rtl/div_share_ctrl_if.sv
// Connection between the sharing controller (master) and the sequential divider (slave).
interface div_share_ctrl_if #(
  parameter int W = 16
);
  logic         div_init;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic [W-1:0] div_result;
  logic         div_done;

  modport master (output div_init, div_a, div_b, input div_result, div_done);
  modport slave  (input div_init, div_a, div_b, output div_result, div_done);
endinterface

// File: rtl/div_share_ctrl_rr_pick.sv
// Rotating-priority pick: first set request strictly after ptr, wrapping modulo N_REQ.
module div_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any_req
);

  logic found;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    any_req = |req;
    for (int o = 1; o <= N_REQ; o++) begin
      int c;
      c = (int'(ptr) + o) % N_REQ;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin controller sharing one sequential divider among N_REQ clients,
// with local divide-by-zero handling and a watchdog on the divider.
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*W-1:0]   a_in,
  input  logic [N_REQ*W-1:0]   b_in,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [W-1:0]         rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  div_share_ctrl_if.master     dif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W-1:0]     res_data;
  logic             res_err;
  logic [TMR_W-1:0] timer;
  logic             wait_first;
  logic             div_init;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             any_req;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;

  div_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  assign sel_a        = a_in[pick_idx*W +: W];
  assign sel_b        = b_in[pick_idx*W +: W];
  assign dif.div_a    = op_a;
  assign dif.div_b    = op_b;
  assign dif.div_init = div_init;

  // Result is staged in res_* so rsp_data/rsp_err only change together with rsp_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= IDX_W'(N_REQ - 1);
      idx        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      res_data   <= '0;
      res_err    <= 1'b0;
      timer      <= '0;
      wait_first <= 1'b0;
      div_init   <= 1'b0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      div_init  <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= any_req;
          if (any_req) begin
            gnt  <= pick_gnt;
            idx  <= pick_idx;
            op_a <= sel_a;
            op_b <= sel_b;
            if (sel_b == '0) begin
              res_data <= DIV0_RESULT[W-1:0];
              res_err  <= 1'b1;
              state    <= ST_RESP;
            end else begin
              state <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          div_init   <= 1'b1;
          timer      <= TMR_W'(TIMEOUT);
          wait_first <= 1'b1;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done still high from the previous operation is skipped on the first cycle.
          wait_first <= 1'b0;
          if (!wait_first && dif.div_done) begin
            res_data <= dif.div_result;
            res_err  <= 1'b0;
            state    <= ST_RESP;
          end else if (timer == TMR_W'(1)) begin
            res_data <= TIMEOUT_RESULT[W-1:0];
            res_err  <= 1'b1;
            state    <= ST_RESP;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        ST_RESP: begin
          rsp_valid <= N_REQ'(1) << idx;
          rsp_data  <= res_data;
          rsp_err   <= res_err;
          ptr       <= idx;
          busy      <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl with a behavioural sequential divider.
module tb_div_share_ctrl;
  localparam int N_REQ   = 2;
  localparam int W       = 16;
  localparam int TIMEOUT = 64;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    logic         err;
    int           lat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_in;
  logic [N_REQ*W-1:0] b_in;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   rsp_valid;
  logic [W-1:0]       rsp_data;
  logic               rsp_err;
  logic               busy;

  div_share_ctrl_if #(.W(W)) dif ();

  div_share_ctrl #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .dif       (dif.master)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb_q[$];
  int   gnt_cyc[N_REQ];
  int   init_cnt = 0;
  logic [W-1:0] init_a, init_b;

  // Divider model knobs
  int m_dly   = 16;
  bit m_hang  = 1'b0;
  bit m_level = 1'b1;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      dif.div_done   <= 1'b0;
      dif.div_result <= '0;
      m_cnt          <= 0;
    end else if (dif.div_init) begin
      dif.div_done <= 1'b0;
      m_cnt        <= m_hang ? 0 : m_dly;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        dif.div_done   <= 1'b1;
        dif.div_result <= dif.div_a / dif.div_b;
      end
    end else if (!m_level) begin
      dif.div_done <= 1'b0;
    end
  end

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) if (gnt[i]) gnt_cyc[i] = cyc;
      if (dif.div_init) begin
        init_cnt++;
        init_a = dif.div_a;
        init_b = dif.div_b;
      end
      if (|rsp_valid) begin
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rsp_idx",  32'(rsp_valid), 32'(1) << e.idx);
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_err",  32'(rsp_err), 32'(e.err));
          chk("rsp_busy", 32'(busy), 32'd1);
          if (e.lat > 0) chk("rsp_latency", 32'(cyc - gnt_cyc[e.idx]), 32'(e.lat));
        end
      end
    end
  end

  task automatic push(input int idx, input logic [W-1:0] data, input logic err, input int lat);
    exp_t e;
    e.idx = idx; e.data = data; e.err = err; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[k*W +: W] = a;
    b_in[k*W +: W] = b;
  endtask

  task automatic wait_gnt(input int k, input int max);
    int n = 0;
    while (!gnt[k] && n < max) begin @(negedge clk); n++; end
    if (!gnt[k]) chk("gnt_wait_expired", 32'(k), 32'hFFFF_FFFF);
  endtask

  task automatic hold_until_grants(input int ngr, input int max);
    int seen = 0;
    int n    = 0;
    while (seen < ngr && n < max) begin
      @(negedge clk); n++;
      if (|gnt) seen++;
    end
    req = '0;
    if (seen < ngr) chk("grant_count_expired", 32'(seen), 32'(ngr));
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < max) begin @(negedge clk); n++; end
    if (sb_q.size() != 0 || busy) chk("drain_expired", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic run_one(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] d, input logic e, input int lat);
    set_ops(k, a, b);
    push(k, d, e, lat);
    req[k] = 1'b1;
    wait_gnt(k, 50);
    req[k] = 1'b0;
    wait_drain(300);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ic;
    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_gnt",  32'(gnt), 32'd0);
    chk("reset_rsp",  32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_init", 32'(dif.div_init), 32'd0);
    chk("reset_div_a", 32'(dif.div_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single divide, pulsed done after 16 cycles
    m_dly = 16; m_level = 1'b0; ic = init_cnt;
    run_one(0, 16'd100, 16'd7, 16'd14, 1'b0, 4 + 16);
    chk("t1_init_cycles", 32'(init_cnt - ic), 32'd1);
    chk("t1_div_a", 32'(init_a), 32'd100);
    chk("t1_div_b", 32'(init_b), 32'd7);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // 3: divide by zero, divider untouched
    ic = init_cnt;
    run_one(1, 16'd1234, 16'd0, 16'hFFFF, 1'b1, 1);
    chk("t3_no_init", 32'(init_cnt - ic), 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_hold_data", 32'(rsp_data), 32'hFFFF);
    chk("t3_hold_err",  32'(rsp_err), 32'd1);

    // 2: both clients held, alternating service
    m_dly = 5; m_level = 1'b1;
    set_ops(0, 16'd50, 16'd5);
    set_ops(1, 16'd9, 16'd3);
    push(0, 16'd10, 1'b0, 9);
    push(1, 16'd3,  1'b0, 9);
    push(0, 16'd10, 1'b0, 9);
    push(1, 16'd3,  1'b0, 9);
    req = 2'b11;
    hold_until_grants(4, 200);
    wait_drain(300);

    // 4: divider never completes, then a normal operation
    m_hang = 1'b1;
    run_one(0, 16'd500, 16'd3, 16'd0, 1'b1, TIMEOUT + 2);
    m_hang = 1'b0; m_dly = 4; m_level = 1'b1;
    run_one(1, 16'd77, 16'd7, 16'd11, 1'b0, 8);

    // 5: done still high from previous op at launch time
    chk("t5_stale_done", 32'(dif.div_done), 32'd1);
    m_dly = 6;
    run_one(0, 16'd200, 16'd10, 16'd20, 1'b0, 10);

    // 6: reset while waiting on the divider
    m_hang = 1'b1;
    set_ops(1, 16'd5, 16'd1);
    req[1] = 1'b1;
    wait_gnt(1, 50);
    req[1] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_rsp",  32'(rsp_valid), 32'd0);
    chk("t6_rst_div",  32'({dif.div_init, dif.div_a, dif.div_b}), 32'd0);
    chk("t6_rst_data", 32'({rsp_err, rsp_data, gnt}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_hang = 1'b0; m_dly = 3;
    set_ops(0, 16'd8, 16'd2);
    set_ops(1, 16'd9, 16'd3);
    push(0, 16'd4, 1'b0, 7);
    push(1, 16'd3, 1'b0, 7);
    req = 2'b11;
    hold_until_grants(2, 100);
    wait_drain(300);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Round-robin controller that lets N_REQ clients share one 16-bit sequential divider (init pulse in, done/result out).
- Sits between client blocks and the divider instance.
- Per operation: arbitrates, captures operands, launches the divider, supervises it with a watchdog, and returns the quotient to the granted client.
- Handles divide-by-zero locally, without launching the divider.

Parameters:
N_REQ, 2, number of requesting clients (2..8)
W, 16, operand/result width; must match the divider
TIMEOUT, 64, max cycles waited for div_done before abort (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req  in  N_REQ  per-client request; held high with operands stable until gnt
a_in  in  N_REQ*W  dividends, client i at bits [i*W +: W]
b_in  in  N_REQ*W  divisors, same packing
gnt  out  N_REQ  one-cycle one-hot pulse; operands of that client captured this cycle
rsp_valid  out  N_REQ  one-cycle one-hot pulse; rsp_data/rsp_err valid
rsp_data  out  W  quotient for the client flagged in rsp_valid
rsp_err  out  1  1 = divide-by-zero or timeout
busy  out  1  high from grant cycle through response cycle
div_init  out  1  divider start, one-cycle pulse
div_a  out  W  captured dividend, stable from LAUNCH until back in IDLE
div_b  out  W  captured divisor, same stability
div_result  in  W  divider quotient
div_done  in  1  divider completion (level or pulse accepted)

Behaviour:
- Clock and reset: one clock. rst is asynchronous and active-high. Reset values:
  - all outputs 0, state IDLE, round-robin pointer so client 0 has top priority, timer 0.
- States: IDLE, LAUNCH, WAIT, RESP. Registered outputs, one-hot state encoding.
- IDLE:
  - If any req bit is set, pick client k: first set bit scanning from ptr+1 upward, modulo N_REQ.
  - Same cycle: gnt[k]=1, capture a/b of client k into op_a/op_b, latch idx=k, busy=1.
  - Captured b==0: go to RESP with data={W{1}} and err=1. The divider is never touched.
  - Otherwise go to LAUNCH.
  - No req set: stay in IDLE, gnt=0, busy=0.
- LAUNCH:
  - div_init=1 for exactly this cycle.
  - div_a/div_b already carry op_a/op_b.
  - Timer loaded with TIMEOUT. Go to WAIT.
- WAIT:
  - div_init=0.
  - div_done is ignored in the first WAIT cycle (flag wait_first), so a level done left over from the previous operation is not taken.
  - After that, div_done=1 → capture div_result, err=0, go to RESP.
  - Otherwise, if timer==1 → data=0, err=1, go to RESP.
  - Otherwise timer decrements.
  - If done and timer expiry coincide, done wins.
- RESP:
  - rsp_valid[idx]=1 for one cycle, with rsp_data and rsp_err.
  - ptr<=idx. Go to IDLE.
  - rsp_data/rsp_err hold their value until the next RESP. Receivers sample only on rsp_valid.
- Latency, divider path: gnt to rsp_valid is 3 + d cycles, where d is the count of WAIT cycles after the first one until done is seen.
- Latency, divide-by-zero: gnt to rsp_valid is 1 cycle.
- Request rules:
  - At most one grant per operation; new grants only from IDLE.
  - req still high in IDLE after a response is treated as a new request.
  - Clients drop req the cycle after gnt unless issuing another operation.
  - A req that drops before being granted is simply never served.
- Reset mid-operation: immediate return to reset values, with no rsp_valid for the aborted operation. The divider is re-initialised by the next div_init.
- Arithmetic: unsigned quotient only (the divider's result). Widths are exactly W with no extension.

Decomposition:
- Package div_share_pkg:
  - state encoding constants
  - DIV0_RESULT ({W{1}})
  - TIMEOUT_RESULT (0)
  - timer width constant (8)
- One natural sub-module: div_rr_pick.
  - Combinational rotate-priority pick: inputs req and ptr; outputs one-hot grant, index and any_req.
  - Instantiated once in IDLE decode.

Test Plan:
1. Client 0 requests A=100, B=7; divider model with done after 16 cycles → gnt[0] one cycle; div_init one cycle with div_a=100, div_b=7; rsp_valid[0] with rsp_data=14, rsp_err=0; busy deasserts after RESP.
2. Clients 0 and 1 both request in the same cycle (A0=50/B0=5, A1=9/B1=3), held continuously → service order 0,1,0,1; responses 10 and 3; never two consecutive grants to the same client while the other waits.
3. Client 1 requests A=1234, B=0 → gnt[1], then rsp_valid[1] the next cycle with rsp_data=16'hFFFF, rsp_err=1; div_init never asserted.
4. Divider stub whose div_done stays low → rsp_valid after exactly TIMEOUT WAIT cycles (64) with rsp_data=0, rsp_err=1; next request is served normally.
5. div_done held high from the previous operation into the next launch → stale done ignored in the first WAIT cycle; the result is taken only on a fresh done. Check with A=200, B=10 → 20.
6. rst asserted in WAIT → all outputs 0 asynchronously with no rsp_valid; after release, a simultaneous request from clients 0 and 1 grants client 0 first.
